serial_tx6: RTL and testbench
=============================

SERIAL_TX6 -- requirements
Module: serial_tx6

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 4, giving clock cycles per serial bit; legal range 1..255.
REQ-002 The block SHALL have port Clk, input, 1 bit; positive-edge clock for all state.
REQ-003 The block SHALL have port reset, input, 1 bit; synchronous, active-high reset.
REQ-004 The block SHALL have port D, input, 6 bits; parallel data word to transmit.
REQ-005 The block SHALL have port Load, input, 1 bit; request to transmit D.
REQ-006 The block SHALL have port Dir, input, 1 bit; bit order, 0 = LSB first, 1 = MSB first.
REQ-007 The block SHALL have port Ready, output, 1 bit; high when a Load will be accepted.
REQ-008 The block SHALL have port Busy, output, 1 bit; high while a frame is on the line.
REQ-009 The block SHALL have port SO, output, 1 bit; serial line, idle high.
REQ-010 The block SHALL have port Done, output, 1 bit; one-cycle pulse at frame completion.

Function
REQ-011 The block SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-012 In IDLE: SO=1, Ready=1, Busy=0.
REQ-013 Accept SHALL occur at a rising edge where state=IDLE and Load=1; D and Dir are captured into internal registers at that edge.
REQ-014 After accept, the next cycle SHALL be the first cycle of START with SO=0, Busy=1, Ready=0.
REQ-015 Each of START, each DATA bit, PARITY and STOP SHALL hold SO for exactly BAUD_DIV cycles; bit-period counter wraps from BAUD_DIV-1 to 0.
REQ-016 DATA SHALL emit 6 bits from the captured word: Dir=0 order b0..b5, Dir=1 order b5..b0; 3-bit bit index advances only at bit-period wrap.
REQ-017 PARITY SHALL emit even parity, i.e., XOR of the 6 captured bits.
REQ-018 STOP SHALL emit SO=1.
REQ-019 Frame length SHALL be 9*BAUD_DIV cycles from the first START cycle to the last STOP cycle inclusive.
REQ-020 After the last STOP cycle the FSM SHALL enter IDLE; Done=1 during exactly that first IDLE cycle, and Done=0 at all other times.
REQ-021 Load SHALL be ignored whenever state is not IDLE; no queuing.
REQ-022 Changes on D or Dir after accept SHALL NOT affect the frame in progress.
REQ-023 Load held high continuously SHALL yield back-to-back frames separated by exactly one IDLE cycle (the Done cycle).
REQ-024 With BAUD_DIV=1, each bit SHALL last one cycle and the frame SHALL last 9 cycles.
REQ-025 Outputs SHALL be registered, with no combinational path from inputs to SO, Busy or Done.

Reset
REQ-026 At a rising edge with reset=1, the block SHALL enter IDLE, clear the bit counter and index, and drive SO=1, Ready=1, Busy=0, Done=0 in the following cycle.
REQ-027 Reset SHALL take priority over Load at the same edge.
REQ-028 Reset mid-frame SHALL abort the frame without a Done pulse; captured data is discarded.
REQ-029 Reset deasserted while SO is idle SHALL produce no glitch on SO.

Verification (BAUD_DIV=4, accept edge = cycle 0)
REQ-030 Reset, then idle 10 cycles -> SO=1, Ready=1, Busy=0, Done=0 throughout.
REQ-031 D=6'b101100, Dir=0, Load pulse -> SO by 4-cycle slot from cycle 1: 0 | 0,0,1,1,0,1 | 1 | 1; Done=1 at cycle 37 only.
REQ-032 D=6'b101100, Dir=1 -> data slots 1,0,1,1,0,0, parity 1, stop 1; Done at cycle 37.
REQ-033 Frame with D=6'b101100 and D changed to 6'b010011 plus Load pulses at cycles 5 and 20 -> original frame unchanged, no second frame, single Done.
REQ-034 Frame with D=6'b111111 and reset=1 at cycle 10 -> SO=1, Ready=1, Busy=0 from cycle 11, no Done; a new Load of D=6'b000000 then sends data 0s, parity 0 correctly.
REQ-035 Load held high with D=6'b111111 -> parity 0; first frame Done at cycle 37, second START begins cycle 38, second Done at cycle 74.

Source files
------------

// File: rtl/serial_tx6.sv
// 6-bit serial transmitter: start(0), 6 data bits, even parity, stop(1), BAUD_DIV cycles per bit.
// Frame starts the cycle after Load is accepted in IDLE; Load is ignored while a frame is on the line.
module serial_tx6 #(
    parameter int BAUD_DIV = 4
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic [5:0] D,
    input  logic       Load,
    input  logic       Dir,
    output logic       Ready,
    output logic       Busy,
    output logic       SO,
    output logic       Done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [7:0] LAST = 8'(BAUD_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [5:0] data_q, data_d;
    logic       dir_q, dir_d;
    logic       done_q, done_d;
    logic       so_q, so_d;
    logic       busy_q, busy_d;
    logic       wrap;

    assign wrap  = (cnt_q == LAST);
    assign SO    = so_q;
    assign Busy  = busy_q;
    assign Ready = ~busy_q;
    assign Done  = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        so_d    = 1'b1;
        busy_d  = 1'b0;

        if (state_q == IDLE) begin
            cnt_d = 8'd0;
            idx_d = 3'd0;
        end else begin
            cnt_d = wrap ? 8'd0 : cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (Load) begin
                    state_d = START;
                    data_d  = D;
                    dir_d   = Dir;
                end
            end
            START: begin
                if (wrap) state_d = DATA;
            end
            DATA: begin
                if (wrap) begin
                    if (idx_q == 3'd5) begin
                        state_d = PARITY;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (wrap) state_d = STOP;
            end
            STOP: begin
                if (wrap) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is computed from next state so SO/Busy come straight off flops.
        case (state_d)
            START:   so_d = 1'b0;
            DATA:    so_d = dir_d ? data_d[3'd5 - idx_d] : data_d[idx_d];
            PARITY:  so_d = ^data_d;
            default: so_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= 3'd0;
            data_q  <= 6'd0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            so_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            so_q    <= so_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_serial_tx6.sv
// Bench for serial_tx6: BAUD_DIV=4 and BAUD_DIV=1 instances share stimulus, each against a frame-level model.
module tb_serial_tx6;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       Load = 1'b0;
    logic       Dir = 1'b0;
    logic [5:0] D = 6'd0;
    logic [1:0] rdy_w, bsy_w, so_w, dn_w;

    int passes = 0;
    int total  = 0;
    int cyc    = 0;

    // Model: a frame is a 9-bit list; an active frame is indexed by elapsed cycles.
    int       bdiv[2] = '{4, 1};
    bit       m_act[2];
    int       m_t[2];
    bit       m_done[2];
    bit [8:0] m_frame[2];

    always #5 Clk = ~Clk;

    serial_tx6 #(.BAUD_DIV(4)) u4 (
        .Clk(Clk), .reset(reset), .D(D), .Load(Load), .Dir(Dir),
        .Ready(rdy_w[0]), .Busy(bsy_w[0]), .SO(so_w[0]), .Done(dn_w[0])
    );

    serial_tx6 #(.BAUD_DIV(1)) u1 (
        .Clk(Clk), .reset(reset), .D(D), .Load(Load), .Dir(Dir),
        .Ready(rdy_w[1]), .Busy(bsy_w[1]), .SO(so_w[1]), .Done(dn_w[1])
    );

    function automatic bit [8:0] build(input logic [5:0] d, input logic dir);
        bit [8:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 6; i++) f[1 + i] = dir ? d[5 - i] : d[i];
        f[7] = ^d;
        f[8] = 1'b1;
        return f;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_act[k]  = 1'b0;
                m_done[k] = 1'b0;
            end else if (!m_act[k]) begin
                m_done[k] = 1'b0;
                if (Load) begin
                    m_act[k]   = 1'b1;
                    m_t[k]     = 0;
                    m_frame[k] = build(D, Dir);
                end
            end else if (m_t[k] == 9 * bdiv[k] - 1) begin
                m_act[k]  = 1'b0;
                m_done[k] = 1'b1;
            end else begin
                m_t[k] = m_t[k] + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input int k, input logic obs, input logic exp);
        total = total + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s[div=%0d] cycle=%0d observed=%b expected=%b", tag, bdiv[k], cyc, obs, exp);
    endtask

    task automatic tick();
        logic exp_so;
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        cyc = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            exp_so = m_act[k] ? m_frame[k][m_t[k] / bdiv[k]] : 1'b1;
            chk("SO", k, so_w[k], exp_so);
            chk("Busy", k, bsy_w[k], m_act[k]);
            chk("Ready", k, rdy_w[k], !m_act[k]);
            chk("Done", k, dn_w[k], m_done[k]);
        end
    endtask

    initial begin
        // Reset then idle
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (10) tick();

        // LSB-first and MSB-first frames of 101100
        for (int dir = 0; dir < 2; dir++) begin
            D = 6'b101100; Dir = 1'(dir); Load = 1'b1;
            tick();
            Load = 1'b0;
            repeat (40) tick();
        end

        // Input changes and Load pulses mid-frame must be ignored
        D = 6'b101100; Dir = 1'b0; Load = 1'b1;
        tick();
        Load = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (i >= 3) begin
                D   = 6'b010011;
                Dir = 1'b1;
            end
            Load = (i == 5) || (i == 20);
            tick();
        end
        Load = 1'b0;
        repeat (4) tick();

        // Reset mid-frame, then a clean all-zero frame
        D = 6'b111111; Dir = 1'b0; Load = 1'b1;
        tick();
        Load = 1'b0;
        repeat (9) tick();
        reset = 1'b1; Load = 1'b1;
        tick();
        reset = 1'b0; Load = 1'b0;
        repeat (3) tick();
        D = 6'b000000; Load = 1'b1;
        tick();
        Load = 1'b0;
        repeat (40) tick();

        // Load held high: back-to-back frames with one Done cycle between
        D = 6'b111111; Load = 1'b1;
        repeat (80) tick();
        Load = 1'b0;
        repeat (40) tick();

        // Randomized traffic with occasional resets
        repeat (1500) begin
            D     = 6'($urandom);
            Dir   = 1'($urandom);
            Load  = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset = 1'b0; Load = 1'b0;
        repeat (40) tick();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
